// File: rtl/raycast_pkg.sv
`default_nettype none
// ============================================================================
// raycast_pkg : shared FSM encoding, pixel constants and Wishbone cycle codes
// Revision    : 1.0
// ============================================================================
package raycast_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   localparam logic [7:0]  PIX_ALPHA = 8'hFF;
   localparam logic [31:0] PIX_MISS  = 32'h0000_0000;

   localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
   localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

   // Deeper octree levels shade darker; level 31 still leaves a non-zero grey.
   function automatic logic [31:0] shade_pixel(input logic leaf, input logic [4:0] level);
      logic [7:0] s;
      s = PIX_ALPHA - {level, 3'b000};
      return leaf ? {PIX_ALPHA, s, s, s} : PIX_MISS;
   endfunction

endpackage
`default_nettype wire

// File: rtl/raycast_fifo.sv
`default_nettype none
// ============================================================================
// raycast_fifo : small synchronous FIFO with flush, pointer-wrap full/empty
// Revision     : 1.0
// ============================================================================
module raycast_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/raycast_fb_writer.sv
`default_nettype none
// ============================================================================
// raycast_fb_writer : converts ray results to pixels and writes them to the
//                     framebuffer through a classic Wishbone master
// Revision          : 1.0
// ============================================================================
module raycast_fb_writer
   import raycast_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        start_i,
   input  logic [31:0] fb_adr_i,
   input  logic [31:0] ray_count_i,
   input  logic        res_valid_i,
   output logic        res_ready_o,
   input  logic        res_leaf_i,
   input  logic [4:0]  res_level_i,
   output logic [31:0] m_wb_adr_o,
   output logic [31:0] m_wb_dat_o,
   output logic [3:0]  m_wb_sel_o,
   output logic        m_wb_we_o,
   output logic        m_wb_cyc_o,
   output logic        m_wb_stb_o,
   output logic [2:0]  m_wb_cti_o,
   output logic [1:0]  m_wb_bte_o,
   input  logic        m_wb_ack_i,
   input  logic        m_wb_err_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   logic [1:0]  state_q,    state_d;
   logic [31:0] base_q,     base_d;
   logic [31:0] count_q,    count_d;
   logic [31:0] accepted_q, accepted_d;
   logic [31:0] written_q,  written_d;
   logic        gap_q,      gap_d;
   logic        err_q,      err_d;
   logic        done_q,     done_d;

   logic        fifo_full;
   logic        fifo_empty;
   logic [31:0] fifo_head;
   logic        busy;
   logic        bus_active;
   logic        bus_done;
   logic        push;

   raycast_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (wb_clk),
      .rst_n     (wb_rst),
      .flush     (start_i),
      .push      (push),
      .push_data (shade_pixel(res_leaf_i, res_level_i)),
      .pop       (bus_done),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // start_i masks the bus and the result port so an abort neither completes
   // a write nor accepts a result that the flush would immediately discard.
   assign busy        = (state_q == ST_ISSUE) || (state_q == ST_FINISH);
   assign bus_active  = (state_q == ST_ISSUE) && !fifo_empty && !gap_q && !start_i;
   assign bus_done    = bus_active && (m_wb_ack_i || m_wb_err_i);
   assign res_ready_o = busy && !fifo_full && (accepted_q < count_q) && !start_i;
   assign push        = res_valid_i && res_ready_o;

   assign m_wb_cyc_o = bus_active;
   assign m_wb_stb_o = bus_active;
   assign m_wb_we_o  = bus_active;
   assign m_wb_sel_o = bus_active ? 4'hF : 4'h0;
   assign m_wb_adr_o = bus_active ? (base_q + {written_q[29:0], 2'b00}) : 32'h0;
   assign m_wb_dat_o = bus_active ? fifo_head : 32'h0;
   assign m_wb_cti_o = WB_CTI_CLASSIC;
   assign m_wb_bte_o = WB_BTE_LINEAR;

   assign busy_o = busy;
   assign done_o = done_q;
   assign err_o  = err_q;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      count_d    = count_q;
      accepted_d = accepted_q;
      written_d  = written_q;
      gap_d      = 1'b0;
      err_d      = err_q;
      done_d     = 1'b0;
      if (push) accepted_d = accepted_q + 32'd1;
      if (start_i) begin
         base_d     = fb_adr_i;
         count_d    = ray_count_i;
         accepted_d = 32'd0;
         written_d  = 32'd0;
         err_d      = 1'b0;
         state_d    = (ray_count_i == 32'd0) ? ST_FINISH : ST_ISSUE;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_ISSUE: begin
               if (bus_done) begin
                  written_d = written_q + 32'd1;
                  gap_d     = 1'b1;
                  if (m_wb_err_i) err_d = 1'b1;
                  if (written_q + 32'd1 == count_q) state_d = ST_FINISH;
               end
            end
            ST_FINISH: begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk) begin
      if (!wb_rst) begin
         state_q    <= ST_IDLE;
         base_q     <= 32'd0;
         count_q    <= 32'd0;
         accepted_q <= 32'd0;
         written_q  <= 32'd0;
         gap_q      <= 1'b0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         count_q    <= count_d;
         accepted_q <= accepted_d;
         written_q  <= written_d;
         gap_q      <= gap_d;
         err_q      <= err_d;
         done_q     <= done_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_raycast_fb_writer.sv
`default_nettype none
// ============================================================================
// tb_raycast_fb_writer : directed self-checking bench for raycast_fb_writer
// Revision             : 1.0
// ============================================================================
module tb_raycast_fb_writer;

   logic        wb_clk = 1'b0;
   logic        wb_rst;
   logic        start_i;
   logic [31:0] fb_adr_i;
   logic [31:0] ray_count_i;
   logic        res_valid_i;
   logic        res_ready_o;
   logic        res_leaf_i;
   logic [4:0]  res_level_i;
   logic [31:0] m_wb_adr_o;
   logic [31:0] m_wb_dat_o;
   logic [3:0]  m_wb_sel_o;
   logic        m_wb_we_o;
   logic        m_wb_cyc_o;
   logic        m_wb_stb_o;
   logic [2:0]  m_wb_cti_o;
   logic [1:0]  m_wb_bte_o;
   logic        m_wb_ack_i;
   logic        m_wb_err_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   int          ack_delay = 1;
   int          err_idx   = -1;
   int          wait_cnt  = 0;
   int          n_log     = 0;
   logic [31:0] adr_log [64];
   logic [31:0] dat_log [64];
   int          done_cnt  = 0;
   int          cyc_seen  = 0;
   logic [31:0] exp_dat [8];

   always #5 wb_clk = ~wb_clk;

   raycast_fb_writer #(.FIFO_DEPTH(4)) dut (
      .wb_clk      (wb_clk),
      .wb_rst      (wb_rst),
      .start_i     (start_i),
      .fb_adr_i    (fb_adr_i),
      .ray_count_i (ray_count_i),
      .res_valid_i (res_valid_i),
      .res_ready_o (res_ready_o),
      .res_leaf_i  (res_leaf_i),
      .res_level_i (res_level_i),
      .m_wb_adr_o  (m_wb_adr_o),
      .m_wb_dat_o  (m_wb_dat_o),
      .m_wb_sel_o  (m_wb_sel_o),
      .m_wb_we_o   (m_wb_we_o),
      .m_wb_cyc_o  (m_wb_cyc_o),
      .m_wb_stb_o  (m_wb_stb_o),
      .m_wb_cti_o  (m_wb_cti_o),
      .m_wb_bte_o  (m_wb_bte_o),
      .m_wb_ack_i  (m_wb_ack_i),
      .m_wb_err_i  (m_wb_err_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wishbone slave: acks (or errs) after ack_delay stalled cycles, logs writes.
   always @(negedge wb_clk) begin
      if (m_wb_ack_i || m_wb_err_i) begin
         m_wb_ack_i = 1'b0;
         m_wb_err_i = 1'b0;
         chk("stb_gap_after_ack", {31'd0, m_wb_stb_o}, 32'd0);
      end else if (m_wb_stb_o) begin
         if (wait_cnt >= ack_delay) begin
            wait_cnt = 0;
            chk("bus_we_sel_cti_bte", {24'd0, m_wb_we_o, m_wb_cyc_o, m_wb_sel_o, m_wb_cti_o != 3'b000, m_wb_bte_o != 2'b00},
                32'h0000_00FC);
            if (n_log < 64) begin
               adr_log[n_log] = m_wb_adr_o;
               dat_log[n_log] = m_wb_dat_o;
            end
            if (n_log == err_idx) m_wb_err_i = 1'b1;
            else                  m_wb_ack_i = 1'b1;
            n_log++;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   end

   always @(negedge wb_clk) begin
      if (done_o)     done_cnt++;
      if (m_wb_cyc_o) cyc_seen++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic start_frame(input logic [31:0] base, input logic [31:0] cnt);
      @(negedge wb_clk);
      start_i     = 1'b1;
      fb_adr_i    = base;
      ray_count_i = cnt;
      @(negedge wb_clk);
      start_i = 1'b0;
   endtask

   task automatic send(input logic leaf, input logic [4:0] lvl);
      bit ok;
      ok          = 1'b0;
      res_valid_i = 1'b1;
      res_leaf_i  = leaf;
      res_level_i = lvl;
      for (int i = 0; i < 400 && !ok; i++) begin
         #1;
         if (res_ready_o) ok = 1'b1;
         @(negedge wb_clk);
      end
      res_valid_i = 1'b0;
      chk("send_accepted", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_done(input int limit);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         @(negedge wb_clk);
         #1;
         if (done_o) seen = 1'b1;
      end
      chk("done_seen", {31'd0, seen}, 32'd1);
   endtask

   initial begin
      int d0;
      int c0;
      wb_rst      = 1'b0;
      start_i     = 1'b0;
      fb_adr_i    = 32'h0;
      ray_count_i = 32'h0;
      res_valid_i = 1'b0;
      res_leaf_i  = 1'b0;
      res_level_i = 5'd0;
      m_wb_ack_i  = 1'b0;
      m_wb_err_i  = 1'b0;
      exp_dat[0] = 32'hFFFF_FFFF; exp_dat[1] = 32'hFFF7_F7F7;
      exp_dat[2] = 32'hFFEF_EFEF; exp_dat[3] = 32'h0000_0000;
      exp_dat[4] = 32'hFFDF_DFDF; exp_dat[5] = 32'hFFD7_D7D7;
      exp_dat[6] = 32'hFFCF_CFCF; exp_dat[7] = 32'hFFC7_C7C7;

      // Reset state
      repeat (3) @(negedge wb_clk);
      #1;
      chk("rst_adr", m_wb_adr_o, 32'h0);
      chk("rst_dat", m_wb_dat_o, 32'h0);
      chk("rst_ctrl", {18'd0, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o},
          32'h0);
      chk("rst_status", {28'd0, busy_o, done_o, err_o, res_ready_o}, 32'h0);
      @(negedge wb_clk);
      wb_rst = 1'b1;

      // Basic three-pixel frame
      n_log = 0; d0 = done_cnt; ack_delay = 1;
      start_frame(32'h0000_1000, 32'd3);
      #1;
      chk("busy_after_start", {31'd0, busy_o}, 32'd1);
      send(1'b1, 5'd5);
      #1;
      chk("stb_latency", {31'd0, m_wb_stb_o}, 32'd1);
      chk("first_adr", m_wb_adr_o, 32'h0000_1000);
      send(1'b0, 5'd7);
      send(1'b1, 5'd0);
      wait_done(200);
      repeat (3) @(negedge wb_clk);
      #1;
      chk("s1_nwrites", n_log, 32'd3);
      chk("s1_adr0", adr_log[0], 32'h0000_1000);
      chk("s1_dat0", dat_log[0], 32'hFFD7_D7D7);
      chk("s1_adr1", adr_log[1], 32'h0000_1004);
      chk("s1_dat1", dat_log[1], 32'h0000_0000);
      chk("s1_adr2", adr_log[2], 32'h0000_1008);
      chk("s1_dat2", dat_log[2], 32'hFFFF_FFFF);
      chk("s1_done_pulses", done_cnt - d0, 32'd1);
      chk("s1_err", {31'd0, err_o}, 32'd0);
      res_valid_i = 1'b1;
      #1;
      chk("idle_ready_low", {31'd0, res_ready_o}, 32'd0);
      res_valid_i = 1'b0;

      // Zero-length frame
      c0 = cyc_seen;
      @(negedge wb_clk);
      start_i = 1'b1; fb_adr_i = 32'h0000_5000; ray_count_i = 32'd0;
      @(negedge wb_clk);
      start_i = 1'b0;
      #1;
      chk("zero_cycle1_done", {30'd0, busy_o, done_o}, 32'h2);
      @(negedge wb_clk);
      #1;
      chk("zero_cycle2_done", {30'd0, busy_o, done_o}, 32'h1);
      @(negedge wb_clk);
      #1;
      chk("zero_cycle3_done", {30'd0, busy_o, done_o}, 32'h0);
      chk("zero_no_bus", cyc_seen - c0, 32'd0);

      // Back-pressure with stalled slave
      n_log = 0; d0 = done_cnt; ack_delay = 20;
      start_frame(32'h0000_2000, 32'd8);
      send(1'b1, 5'd0);
      send(1'b1, 5'd1);
      send(1'b1, 5'd2);
      send(1'b0, 5'd3);
      #1;
      chk("ready_full", {31'd0, res_ready_o}, 32'd0);
      chk("stall_no_ack", n_log, 32'd0);
      send(1'b1, 5'd4);
      send(1'b1, 5'd5);
      send(1'b1, 5'd6);
      send(1'b1, 5'd7);
      wait_done(1000);
      chk("s3_nwrites", n_log, 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("s3_dat%0d", i), dat_log[i], exp_dat[i]);
         chk($sformatf("s3_adr%0d", i), adr_log[i], 32'h0000_2000 + 32'(4 * i));
      end
      chk("s3_done_pulses", done_cnt - d0, 32'd1);

      // Error on the second write
      n_log = 0; d0 = done_cnt; ack_delay = 1; err_idx = 1;
      start_frame(32'h0000_3000, 32'd3);
      send(1'b1, 5'd1);
      send(1'b1, 5'd2);
      send(1'b1, 5'd3);
      wait_done(200);
      chk("s4_err_set", {31'd0, err_o}, 32'd1);
      chk("s4_nwrites", n_log, 32'd3);
      chk("s4_adr2", adr_log[2], 32'h0000_3008);
      repeat (3) @(negedge wb_clk);
      #1;
      chk("s4_err_sticky", {31'd0, err_o}, 32'd1);
      chk("s4_done_pulses", done_cnt - d0, 32'd1);
      err_idx = -1;

      // Address wrap; start clears err
      n_log = 0;
      start_frame(32'hFFFF_FFFC, 32'd2);
      #1;
      chk("s5_err_cleared", {31'd0, err_o}, 32'd0);
      send(1'b1, 5'd31);
      send(1'b0, 5'd0);
      #1;
      chk("ready_beyond_count", {30'd0, busy_o, res_ready_o}, 32'h2);
      wait_done(200);
      chk("s5_adr0", adr_log[0], 32'hFFFF_FFFC);
      chk("s5_dat0", dat_log[0], 32'hFF07_0707);
      chk("s5_adr1", adr_log[1], 32'h0000_0000);

      // Abort by start_i during a pending strobe
      n_log = 0; ack_delay = 1000;
      start_frame(32'h0000_4000, 32'd2);
      send(1'b1, 5'd2);
      #1;
      chk("s6_pending", {31'd0, m_wb_stb_o}, 32'd1);
      @(negedge wb_clk);
      start_i = 1'b1; fb_adr_i = 32'h0000_6000; ray_count_i = 32'd1;
      #1;
      chk("s6_cyc_drop_same", {31'd0, m_wb_cyc_o}, 32'd0);
      ack_delay = 1;
      @(negedge wb_clk);
      start_i = 1'b0;
      #1;
      chk("s6_flushed", {30'd0, busy_o, m_wb_cyc_o}, 32'h2);
      send(1'b1, 5'd4);
      wait_done(200);
      chk("s6_nwrites", n_log, 32'd1);
      chk("s6_adr0", adr_log[0], 32'h0000_6000);
      chk("s6_dat0", dat_log[0], 32'hFFDF_DFDF);

      // Reset mid-transfer
      n_log = 0; ack_delay = 1000;
      start_frame(32'h0000_7000, 32'd2);
      send(1'b1, 5'd1);
      #1;
      chk("s7_pending", {31'd0, m_wb_stb_o}, 32'd1);
      @(negedge wb_clk);
      wb_rst = 1'b0;
      @(negedge wb_clk);
      #1;
      chk("s7_rst_bus", {m_wb_adr_o[30:0], m_wb_cyc_o}, 32'h0);
      chk("s7_rst_status", {28'd0, busy_o, done_o, err_o, res_ready_o}, 32'h0);
      ack_delay = 1;
      @(negedge wb_clk);
      wb_rst = 1'b1;
      start_frame(32'h0000_8000, 32'd1);
      send(1'b1, 5'd3);
      wait_done(200);
      chk("s7_nwrites", n_log, 32'd1);
      chk("s7_adr0", adr_log[0], 32'h0000_8000);
      chk("s7_dat0", dat_log[0], 32'hFFE7_E7E7);

      repeat (2) @(negedge wb_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
